// File: rtl/uart_mem_loader.sv
// UART packet loader: 8N1 receiver, packet parser and checksum check feeding a memory write port.
// Optional inter-byte timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_mem_loader #(
  parameter int BAUD_DIV    = 434,
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 69440
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        rx_data_peek
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] P_WAIT_SYNC = 3'd0;
  localparam logic [2:0] P_AHI       = 3'd1;
  localparam logic [2:0] P_ALO       = 3'd2;
  localparam logic [2:0] P_LEN       = 3'd3;
  localparam logic [2:0] P_DATA      = 3'd4;
  localparam logic [2:0] P_CSUM      = 3'd5;

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]        rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;
  logic              ferr_q, ferr_d;
  logic [7:0]        peek_q, peek_d;

  logic [2:0]        p_state_q, p_state_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [8:0]        remain_q, remain_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [7:0]        mem_wr_data_q, mem_wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
`endif

  // Receiver: start bit is verified at mid-bit, then every bit is sampled at its centre.
  always_comb begin
    sync1_d      = rxd;
    sync2_d      = sync1_q;
    rx_state_d   = rx_state_q;
    baud_cnt_d   = baud_cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    ferr_d       = 1'b0;
    peek_d       = peek_q;
    case (rx_state_q)
      RX_IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        if (!sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (baud_cnt_q == HALF_END) begin
          baud_cnt_d = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == BIT_END) begin
          baud_cnt_d = '0;
          shift_d    = {sync2_q, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (baud_cnt_q == BIT_END) begin
          rx_state_d = RX_IDLE;
          if (sync2_q) begin
            byte_valid_d = 1'b1;
            peek_d       = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Parser: one state per received byte; peek_q holds the byte while byte_valid_q is high.
  always_comb begin
    p_state_d     = p_state_q;
    sum_d         = sum_q;
    addr_hi_d     = addr_hi_q;
    waddr_d       = waddr_q;
    remain_d      = remain_q;
    mem_wr_d      = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    if (byte_valid_q) begin
      case (p_state_q)
        P_WAIT_SYNC: begin
          if (peek_q == 8'hA5) begin
            sum_d     = 8'h00;
            p_state_d = P_AHI;
          end
        end
        P_AHI: begin
          sum_d     = sum_q + peek_q;
          addr_hi_d = peek_q;
          p_state_d = P_ALO;
        end
        P_ALO: begin
          sum_d     = sum_q + peek_q;
          waddr_d   = ADDR_W'({addr_hi_q, peek_q});
          p_state_d = P_LEN;
        end
        P_LEN: begin
          sum_d     = sum_q + peek_q;
          remain_d  = (peek_q == 8'h00) ? 9'd256 : {1'b0, peek_q};
          p_state_d = P_DATA;
        end
        P_DATA: begin
          sum_d         = sum_q + peek_q;
          mem_wr_d      = 1'b1;
          mem_wr_addr_d = waddr_q;
          mem_wr_data_d = peek_q;
          waddr_d       = waddr_q + ADDR_W'(1);
          remain_d      = remain_q - 9'd1;
          if (remain_q == 9'd1) p_state_d = P_CSUM;
        end
        default: begin
          if (8'(sum_q + peek_q) == 8'h00) done_d = 1'b1;
          else                             err_d  = 1'b1;
          p_state_d = P_WAIT_SYNC;
        end
      endcase
    end else if (ferr_q && p_state_q != P_WAIT_SYNC) begin
      err_d     = 1'b1;
      p_state_d = P_WAIT_SYNC;
    end
`ifdef UART_LOADER_TIMEOUT_EN
    tmo_cnt_d = (byte_valid_q || p_state_q == P_WAIT_SYNC) ? '0 : tmo_cnt_q + TMO_W'(1);
    if (!byte_valid_q && p_state_q != P_WAIT_SYNC && tmo_cnt_q == TMO_END) begin
      err_d     = 1'b1;
      p_state_d = P_WAIT_SYNC;
      tmo_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    baud_cnt_q <= baud_cnt_d;
    bit_idx_q  <= bit_idx_d;
    shift_q    <= shift_d;
    sum_q      <= sum_d;
    addr_hi_q  <= addr_hi_d;
    waddr_q    <= waddr_d;
    remain_q   <= remain_d;
    if (rst) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      rx_state_q    <= RX_IDLE;
      byte_valid_q  <= 1'b0;
      ferr_q        <= 1'b0;
      peek_q        <= 8'h00;
      p_state_q     <= P_WAIT_SYNC;
      mem_wr_q      <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= 8'h00;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      rx_state_q    <= rx_state_d;
      byte_valid_q  <= byte_valid_d;
      ferr_q        <= ferr_d;
      peek_q        <= peek_d;
      p_state_q     <= p_state_d;
      mem_wr_q      <= mem_wr_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      done_q        <= done_d;
      err_q         <= err_d;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_wr       = mem_wr_q;
  assign busy         = (p_state_q != P_WAIT_SYNC);
  assign done         = done_q;
  assign err          = err_q;
  assign rx_data_peek = peek_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: table of packets plus hand-written framing/reset/timeout sequences.
module tb_uart_mem_loader;
  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [13:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_wr, busy, done, err;
  logic [7:0]  rx_data_peek;

  always #5 clk = ~clk;

  uart_mem_loader #(.BAUD_DIV(BAUD), .ADDR_W(14), .TIMEOUT_CYC(500)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr(mem_wr),
    .busy(busy), .done(done), .err(err), .rx_data_peek(rx_data_peek)
  );

  typedef struct packed {
    logic [0:9][7:0]  pkt;
    int               n;
    int               nwr;
    logic [0:1][13:0] wa;
    logic [0:1][7:0]  wd;
    logic             d;
    logic             e;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [13:0] wq_a[$];
  logic [7:0]  wq_d[$];
  int n_done = 0, n_err = 0, n_done_busy = 0;

  always @(negedge clk) begin
    if (mem_wr) begin
      wq_a.push_back(mem_wr_addr);
      wq_d.push_back(mem_wr_data);
    end
    if (done) begin
      n_done++;
      if (busy) n_done_busy++;
    end
    if (err) n_err++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rxd = stop;
    repeat (BAUD) @(negedge clk);
    rxd = 1'b1;
    if (!stop) repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_pkt(input vec_t v);
    for (int i = 0; i < v.n; i++) send_byte(v.pkt[i], 1'b1);
    repeat (30) @(negedge clk);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int w0, d0, e0;
    w0 = wq_a.size();
    d0 = n_done;
    e0 = n_err;
    send_pkt(v);
    chk({tag, " writes"}, wq_a.size() - w0, v.nwr);
    for (int k = 0; k < v.nwr; k++) begin
      if (w0 + k < wq_a.size()) begin
        chk({tag, " wr_addr"}, int'(wq_a[w0 + k]), int'(v.wa[k]));
        chk({tag, " wr_data"}, int'(wq_d[w0 + k]), int'(v.wd[k]));
      end
    end
    chk({tag, " done"}, n_done - d0, int'(v.d));
    chk({tag, " err"}, n_err - e0, int'(v.e));
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " peek"}, int'(rx_data_peek), int'(v.pkt[v.n - 1]));
    chk({tag, " done_with_busy"}, n_done_busy, 0);
  endtask

  function automatic vec_t mkv(input logic [0:9][7:0] p, input int n, input int nwr,
                               input logic [0:1][13:0] wa, input logic [0:1][7:0] wd,
                               input logic d, input logic e);
    vec_t v;
    v.pkt = p; v.n = n; v.nwr = nwr; v.wa = wa; v.wd = wd; v.d = d; v.e = e;
    return v;
  endfunction

  vec_t vt[6];

  initial begin
    int w0, d0, e0;
    vt[0] = mkv({8'hA5, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB, 24'h0}, 7, 2,
                {14'h0010, 14'h0011}, {8'h11, 8'h22}, 1'b1, 1'b0);
    vt[1] = mkv({8'hA5, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h00, 24'h0}, 7, 2,
                {14'h0010, 14'h0011}, {8'h11, 8'h22}, 1'b0, 1'b1);
    vt[2] = vt[0];
    vt[3] = mkv({8'hA5, 8'h3F, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h5B, 24'h0}, 7, 2,
                {14'h3FFF, 14'h0000}, {8'hAA, 8'hBB}, 1'b1, 1'b0);
    vt[4] = mkv({8'h12, 8'hA5, 8'h00, 8'h20, 8'h01, 8'h77, 8'h68, 24'h0}, 7, 1,
                {14'h0020, 14'h0000}, {8'h77, 8'h00}, 1'b1, 1'b0);
    vt[5] = mkv({8'hA5, 8'hC1, 8'h00, 8'h01, 8'hA5, 8'h99, 32'h0}, 6, 1,
                {14'h0100, 14'h0000}, {8'hA5, 8'h00}, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset mem_wr_addr", int'(mem_wr_addr), 0);
    chk("reset mem_wr_data", int'(mem_wr_data), 0);
    chk("reset mem_wr", int'(mem_wr), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    chk("reset peek", int'(rx_data_peek), 0);

    // Short low glitch must be rejected as a false start.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch peek", int'(rx_data_peek), 0);
    chk("glitch busy", int'(busy), 0);

    // Framing error while waiting for sync is silent.
    e0 = n_err;
    send_byte(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_idle err", n_err - e0, 0);
    chk("ferr_idle busy", int'(busy), 0);
    chk("ferr_idle peek", int'(rx_data_peek), 0);

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Framing error on a data byte aborts the packet.
    w0 = wq_a.size(); d0 = n_done; e0 = n_err;
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    send_byte(8'h02, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b0);
    repeat (30) @(negedge clk);
    chk("ferr_data writes", wq_a.size() - w0, 1);
    chk("ferr_data err", n_err - e0, 1);
    chk("ferr_data done", n_done - d0, 0);
    chk("ferr_data busy", int'(busy), 0);
    chk("ferr_data peek", int'(rx_data_peek), 8'h11);
    run_vec("after_ferr", vt[0]);

    // Reset after the LEN byte.
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (5) @(negedge clk);
    chk("midpkt busy_before", int'(busy), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midpkt busy", int'(busy), 0);
    chk("midpkt mem_wr_addr", int'(mem_wr_addr), 0);
    chk("midpkt mem_wr_data", int'(mem_wr_data), 0);
    chk("midpkt peek", int'(rx_data_peek), 0);
    run_vec("after_rst", vt[0]);

    // Truncated packet: one data byte of four, then idle.
    w0 = wq_a.size(); e0 = n_err;
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1); send_byte(8'h01, 1'b1);
    repeat (700) @(negedge clk);
    chk("trunc writes", wq_a.size() - w0, 1);
    if (wq_a.size() > w0) begin
      chk("trunc wr_addr", int'(wq_a[w0]), 0);
      chk("trunc wr_data", int'(wq_d[w0]), 1);
    end
`ifdef UART_LOADER_TIMEOUT_EN
    chk("timeout err", n_err - e0, 1);
    chk("timeout busy", int'(busy), 0);
`else
    chk("no_timeout err", n_err - e0, 0);
    chk("no_timeout busy", int'(busy), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
